// File: rtl/mpu_exec.sv
// rtl/mpu_exec.sv - operand-fetch and result-capture sequencer for the MPU boolean ALU
module mpu_exec #(
    parameter int RF_AW = 4,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [1:0]       cmd_size,
    input  logic [RF_AW-1:0] cmd_ra,
    input  logic [RF_AW-1:0] cmd_rb,
    input  logic [RF_AW-1:0] cmd_rm0,
    input  logic [RF_AW-1:0] cmd_rm1,
    output logic             rf_re,
    output logic [RF_AW-1:0] rf_addr,
    input  logic [63:0]      rf_data,
    output logic [3:0]       alu_op,
    output logic [1:0]       alu_size,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    output logic [63:0]      alu_m0,
    output logic [63:0]      alu_m1,
    input  logic [63:0]      alu_res,
    output logic             res_valid,
    output logic             res_cond,
    output logic             res_err,
    output logic [CNT_W-1:0] hit_count
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_EXEC, S_RESP} state_t;

    localparam logic [1:0] SEL_A  = 2'd0;
    localparam logic [1:0] SEL_B  = 2'd1;
    localparam logic [1:0] SEL_M0 = 2'd2;
    localparam logic [1:0] SEL_M1 = 2'd3;

    state_t             state_q, state_d;
    logic [1:0]         rd_idx_q, rd_idx_d;
    logic [1:0]         rd_num_q, rd_num_d;
    logic               cap_vld_q, cap_vld_d;
    logic [1:0]         cap_sel_q, cap_sel_d;
    logic [RF_AW-1:0]   ra_q, ra_d, rb_q, rb_d, rm0_q, rm0_d, rm1_q, rm1_d;
    logic [3:0]         op_q, op_d;
    logic [1:0]         size_q, size_d;
    logic [63:0]        a_q, a_d, b_q, b_d, m0_q, m0_d, m1_q, m1_d;
    logic               cond_q, cond_d, err_q, err_d;
    logic [CNT_W-1:0]   hit_q, hit_d;
    logic [1:0]         sel;
    logic               unused_res_bits;

    assign unused_res_bits = ^alu_res[63:1];

    // Operand destination for read slot idx of each op's read list.
    function automatic logic [1:0] list_sel(input logic [3:0] op, input logic [1:0] idx);
        case (op)
            4'd1:    list_sel = (idx == 2'd0) ? SEL_A : (idx == 2'd1) ? SEL_M0 : SEL_M1;
            4'd2:    list_sel = (idx == 2'd0) ? SEL_A : (idx == 2'd1) ? SEL_B  : SEL_M0;
            default: list_sel = (idx == 2'd0) ? SEL_A : SEL_B;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        rd_num_d  = rd_num_q;
        cap_vld_d = 1'b0;
        cap_sel_d = cap_sel_q;
        ra_d = ra_q; rb_d = rb_q; rm0_d = rm0_q; rm1_d = rm1_q;
        op_d = op_q; size_d = size_q;
        a_d = a_q; b_d = b_q; m0_d = m0_q; m1_d = m1_q;
        cond_d = cond_q; err_d = err_q; hit_d = hit_q;
        cmd_ready = 1'b0;
        rf_re     = 1'b0;
        rf_addr   = '0;
        res_valid = 1'b0;
        sel       = list_sel(op_q, rd_idx_q);

        // Data of the previous cycle's read lands in its operand register.
        if (cap_vld_q) begin
            case (cap_sel_q)
                SEL_A:   a_d  = rf_data;
                SEL_B:   b_d  = rf_data;
                SEL_M0:  m0_d = rf_data;
                default: m1_d = rf_data;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d = cmd_op; size_d = cmd_size;
                    ra_d = cmd_ra; rb_d = cmd_rb; rm0_d = cmd_rm0; rm1_d = cmd_rm1;
                    a_d = '0; b_d = '0; m0_d = '0; m1_d = '0;
                    rd_idx_d = 2'd0;
                    rd_num_d = (cmd_op == 4'd3) ? 2'd2 : 2'd3;
                    if (cmd_op >= 4'd1 && cmd_op <= 4'd3) begin
                        state_d = S_READ;
                    end else begin
                        err_d   = 1'b1;
                        cond_d  = 1'b0;
                        state_d = S_RESP;
                    end
                end
            end
            S_READ: begin
                rf_re = 1'b1;
                case (sel)
                    SEL_A:   rf_addr = ra_q;
                    SEL_B:   rf_addr = rb_q;
                    SEL_M0:  rf_addr = rm0_q;
                    default: rf_addr = rm1_q;
                endcase
                cap_vld_d = 1'b1;
                cap_sel_d = sel;
                rd_idx_d  = rd_idx_q + 2'd1;
                if (rd_idx_q == rd_num_q - 2'd1) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: state_d = S_EXEC;
            S_EXEC: begin
                cond_d = alu_res[0];
                err_d  = 1'b0;
                if (alu_res[0] && hit_q != '1) begin
                    hit_d = hit_q + CNT_W'(1);
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                res_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            rd_idx_q <= '0; rd_num_q <= '0;
            cap_vld_q <= 1'b0; cap_sel_q <= '0;
            ra_q <= '0; rb_q <= '0; rm0_q <= '0; rm1_q <= '0;
            op_q <= '0; size_q <= '0;
            a_q <= '0; b_q <= '0; m0_q <= '0; m1_q <= '0;
            cond_q <= 1'b0; err_q <= 1'b0; hit_q <= '0;
        end else begin
            state_q <= state_d;
            rd_idx_q <= rd_idx_d; rd_num_q <= rd_num_d;
            cap_vld_q <= cap_vld_d; cap_sel_q <= cap_sel_d;
            ra_q <= ra_d; rb_q <= rb_d; rm0_q <= rm0_d; rm1_q <= rm1_d;
            op_q <= op_d; size_q <= size_d;
            a_q <= a_d; b_q <= b_d; m0_q <= m0_d; m1_q <= m1_d;
            cond_q <= cond_d; err_q <= err_d; hit_q <= hit_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_size  = size_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_m0    = m0_q;
    assign alu_m1    = m1_q;
    assign res_cond  = cond_q;
    assign res_err   = err_q;
    assign hit_count = hit_q;

endmodule

// File: tb/tb_mpu_exec.sv
// tb/tb_mpu_exec.sv - scoreboard bench for mpu_exec
module tb_mpu_exec;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [1:0]  cmd_size = '0;
    logic [3:0]  cmd_ra = '0, cmd_rb = '0, cmd_rm0 = '0, cmd_rm1 = '0;
    logic        rf_re;
    logic [3:0]  rf_addr;
    logic [63:0] rf_data = '0;
    logic [3:0]  alu_op;
    logic [1:0]  alu_size;
    logic [63:0] alu_a, alu_b, alu_m0, alu_m1, alu_res;
    logic        res_valid, res_cond, res_err;
    logic [1:0]  hit_count;

    // Narrow counter so saturation is reachable in a short run.
    mpu_exec #(.RF_AW(4), .CNT_W(2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_size(cmd_size),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rm0(cmd_rm0), .cmd_rm1(cmd_rm1),
        .rf_re(rf_re), .rf_addr(rf_addr), .rf_data(rf_data),
        .alu_op(alu_op), .alu_size(alu_size), .alu_a(alu_a), .alu_b(alu_b),
        .alu_m0(alu_m0), .alu_m1(alu_m1), .alu_res(alu_res),
        .res_valid(res_valid), .res_cond(res_cond), .res_err(res_err), .hit_count(hit_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        cond;
        logic        err;
        logic [1:0]  hit;
        int          cyc;
        logic [3:0]  op;
        logic [63:0] a, b, m0, m1;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  rd_log[$];
    logic [63:0] rf[16];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(posedge sys_clk) rf_data <= rf_re ? rf[rf_addr] : 64'hA5A5_5A5A_DEAD_BEEF;

    logic [63:0] msk;
    logic        alu_bit;
    always_comb begin
        msk = '1;
        case (alu_size)
            2'd0: msk = 64'hFF;
            2'd1: msk = 64'hFFFF;
            2'd2: msk = 64'hFFFF_FFFF;
            default: msk = '1;
        endcase
        alu_bit = 1'b0;
        case (alu_op)
            4'd1: alu_bit = ((alu_a & alu_m0 & msk) == 64'd0) && ((alu_a & alu_m1 & msk) == (alu_m1 & msk));
            4'd2: alu_bit = (alu_a & msk) == (alu_b & msk);
            4'd3: alu_bit = (alu_a & msk) < (alu_b & msk);
            default: alu_bit = 1'b0;
        endcase
        alu_res = {{63{1'b1}}, alu_bit};
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n && rf_re) rd_log.push_back(rf_addr);
        if (sys_rst_n && res_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_res_valid cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_cond", res_cond, e.cond);
                check("res_err", res_err, e.err);
                check("hit_count", hit_count, e.hit);
                check("res_cycle", cyc, e.cyc);
                check("alu_op", alu_op, e.op);
                check("operands", {alu_a, alu_b, alu_m0, alu_m1}, {e.a, e.b, e.m0, e.m1});
            end
        end
    end

    task automatic wait_ready(output int a);
        int n = 0;
        while (!cmd_ready && n < 30) begin
            @(negedge sys_clk);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout cyc=%0d", cyc);
        end
        a = cyc;
    endtask

    task automatic reset_chk(input string nm);
        check(nm, {cmd_ready, rf_re, rf_addr, alu_op, alu_size, res_valid, res_cond, res_err, hit_count},
                  {1'b1, 1'b0, 4'h0, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 2'h0});
        check({nm, "_ops"}, {alu_a, alu_b, alu_m0, alu_m1}, 256'h0);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [1:0] sz,
                           input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rm0, input logic [3:0] rm1,
                           input logic cond, input logic err, input logic [1:0] hit, input int lat,
                           input int nrd, input logic [11:0] rdl,
                           input logic [63:0] ea, input logic [63:0] eb, input logic [63:0] em0, input logic [63:0] em1);
        int   a;
        exp_t e;
        wait_ready(a);
        rd_log.delete();
        cmd_op = op; cmd_size = sz; cmd_ra = ra; cmd_rb = rb; cmd_rm0 = rm0; cmd_rm1 = rm1;
        cmd_valid = 1'b1;
        e.cond = cond; e.err = err; e.hit = hit; e.cyc = a + lat; e.op = op;
        e.a = ea; e.b = eb; e.m0 = em0; e.m1 = em1;
        sb.push_back(e);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        wait_ready(a);
        check("read_count", rd_log.size(), nrd);
        for (int k = 0; k < nrd && k < rd_log.size(); k++) begin
            check("read_addr", rd_log[k], rdl[11-4*k -: 4]);
        end
    endtask

    initial begin
        int a;
        exp_t e;
        for (int i = 0; i < 16; i++) rf[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
        rf[1] = 64'd5;     rf[2] = 64'd7;
        rf[3] = 64'h12AB;  rf[4] = 64'h34AB;  rf[5] = 64'hFF;
        rf[6] = 64'hF0;    rf[7] = 64'h0F;    rf[8] = 64'h0F;  rf[9] = 64'h1F;

        repeat (2) @(negedge sys_clk);
        reset_chk("reset_state");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // lt 5<7, cmp low byte equal, cmp 16b differs, mask pass/fail
        run_cmd(4'd3, 2'd0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 2'd1, 5, 2, 12'h120, 64'd5, 64'd7, 64'd0, 64'd0);
        run_cmd(4'd2, 2'd0, 4'd3, 4'd4, 4'd5, 4'd0, 1'b1, 1'b0, 2'd2, 6, 3, 12'h345, 64'h12AB, 64'h34AB, 64'hFF, 64'd0);
        run_cmd(4'd2, 2'd1, 4'd3, 4'd4, 4'd5, 4'd0, 1'b0, 1'b0, 2'd2, 6, 3, 12'h345, 64'h12AB, 64'h34AB, 64'hFF, 64'd0);
        run_cmd(4'd1, 2'd0, 4'd8, 4'd2, 4'd6, 4'd7, 1'b1, 1'b0, 2'd3, 6, 3, 12'h867, 64'h0F, 64'd0, 64'hF0, 64'h0F);
        run_cmd(4'd1, 2'd0, 4'd9, 4'd2, 4'd6, 4'd7, 1'b0, 1'b0, 2'd3, 6, 3, 12'h967, 64'h1F, 64'd0, 64'hF0, 64'h0F);
        // illegal ops: no reads, operands cleared
        run_cmd(4'd0, 2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, 2'd3, 1, 0, 12'h000, 64'd0, 64'd0, 64'd0, 64'd0);
        run_cmd(4'd5, 2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, 2'd3, 1, 0, 12'h000, 64'd0, 64'd0, 64'd0, 64'd0);
        // true result with counter at all-ones: saturates, error clears
        run_cmd(4'd3, 2'd0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 2'd3, 5, 2, 12'h120, 64'd5, 64'd7, 64'd0, 64'd0);

        // reset in the middle of an op1 read sequence
        wait_ready(a);
        cmd_op = 4'd1; cmd_ra = 4'd8; cmd_rm0 = 4'd6; cmd_rm1 = 4'd7; cmd_valid = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        @(negedge sys_clk);
        check("mid_read_re", rf_re, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        reset_chk("mid_reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_cmd(4'd3, 2'd0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 2'd1, 5, 2, 12'h120, 64'd5, 64'd7, 64'd0, 64'd0);

        // cmd_valid held through three op3 commands
        wait_ready(a);
        cmd_op = 4'd3; cmd_size = 2'd0; cmd_ra = 4'd1; cmd_rb = 4'd2; cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.cond = 1'b1; e.err = 1'b0; e.hit = (k == 0) ? 2'd2 : 2'd3; e.cyc = a + 5 + 6*k;
            e.op = 4'd3; e.a = 64'd5; e.b = 64'd7; e.m0 = 64'd0; e.m1 = 64'd0;
            sb.push_back(e);
        end
        for (int i = 1; i <= 18; i++) begin
            @(negedge sys_clk);
            check("bp_ready", cmd_ready, (i % 6) == 0);
        end
        cmd_valid = 1'b0;
        repeat (8) @(negedge sys_clk);
        check("sb_drained", sb.size(), 0);
        check("final_hits", hit_count, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
